mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- M stage of the 5-stage MIPS pipeline; consumes the E/M register outputs (instruction, PC, ALU result, store data, destination, Tnew).
- Performs data-memory access: word, halfword and byte stores and loads, with sign/zero extension.
- Includes store-data forwarding from W.
- Registers everything into the M/W pipeline register, which feeds the W stage and the hazard unit.

Parameters:
- DM_WORDS, 1024, number of 32-bit words in data memory.
- DM_AW, 10, word-index width; must equal log2(DM_WORDS).
- PC_RESET, 32'h0000_3000, PC value held in M/W after reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instr_m_i  in  32  instruction in M (from E/M)
- pc_m_i  in  32  PC of that instruction
- alurs_m_i  in  32  ALU result; byte address for loads/stores
- wd_m_i  in  32  rt value captured in E (store data before forwarding)
- dst_m_i  in  5  destination register
- tnew_m_i  in  3  cycles until result available
- w_we_i  in  1  W stage writes the register file this cycle
- w_dst_i  in  5  W stage destination register
- w_data_i  in  32  W stage write-back data
- instr_mw_o  out  32  registered instruction
- pc_mw_o  out  32  registered PC
- alurs_mw_o  out  32  registered ALU result
- memrd_mw_o  out  32  registered, extended load data (0 for non-loads)
- dst_mw_o  out  5  registered destination
- tnew_mw_o  out  3  registered Tnew
- addr_err_o  out  1  combinational; misaligned access by the current M instruction

Behaviour:
- Decode uses opcode instr_m_i[31:26]:
  - lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100
  - sw 101011, sh 101001, sb 101000
  - all other opcodes are non-memory.
- Store-data forwarding: if w_we_i=1, w_dst_i!=0 and w_dst_i==instr_m_i[20:16], then store data = w_data_i; otherwise store data = wd_m_i.
- Addressing:
  - Word index = alurs_m_i[DM_AW+1:2]. Upper bits are ignored, so addresses wrap modulo DM_WORDS*4.
  - Byte lane = alurs_m_i[1:0].
- Misalignment:
  - Word access with addr[1:0]!=0 is misaligned. Halfword access with addr[0]!=0 is misaligned.
  - addr_err_o=1 for a misaligned access. The store is suppressed. A misaligned load returns 0.
- Byte enables:
  - sw writes 4'b1111.
  - sh writes 4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1), using data[15:0] replicated to both halves.
  - sb writes a single lane 1<<addr[1:0], using data[7:0] replicated to all lanes.
- Write timing:
  - Writes commit at the rising clk edge while the store is in M.
  - A load in the next cycle to the same word sees the new data; there is no read-before-write hazard.
- Read path: combinational read of the addressed word, then lane select:
  - lw: the whole word.
  - lh/lhu: the halfword selected by addr[1], sign- or zero-extended.
  - lb/lbu: the byte selected by addr[1:0], sign- or zero-extended.
  - The result is registered into memrd_mw_o at the clk edge.
- M/W register, each rising clk edge with reset=0:
  - instr_mw_o, pc_mw_o, alurs_mw_o, dst_mw_o copy their M inputs.
  - memrd_mw_o takes the extended load data.
  - tnew_mw_o = (tnew_m_i!=0) ? tnew_m_i-1 : 0 (saturates at 0).
- Reset (reset=1 at the clk edge):
  - instr_mw_o=0, pc_mw_o=PC_RESET; alurs_mw_o, memrd_mw_o, dst_mw_o and tnew_mw_o all 0.
  - All DM_WORDS memory words are cleared to 0.
  - A store present in M during a reset cycle does not write.
- Latency: one cycle from M inputs to M/W outputs. There is no stall or flush input; upstream inserts bubbles as instr=0 (sll $0, a non-memory op).

Decomposition:
- Shared package mips_pkg holds:
  - opcode localparams (OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB)
  - instruction field bit positions
  - the PC reset constant
- Natural sub-module dm_array:
  - DM_WORDS x 32 storage with 4-bit byte-enable write, synchronous clear on reset, combinational read.
- Decode, forwarding, lane select/extension and the M/W register stay in mem_stage.

Test Plan:
- Reset, then sw $rt=32'hDEADBEEF at addr 0x10, then lw from 0x10 -> memrd_mw_o=32'hDEADBEEF on the cycle after the lw is in M.
- sb 0x80 to addr 0x21; lb 0x21 -> 32'hFFFFFF80; lbu 0x21 -> 32'h00000080; lw 0x20 -> 32'h00008000.
- sh 0x8001 to addr 0x32; lh 0x32 -> 32'hFFFF8001; lhu 0x32 -> 32'h00008001; lw 0x30 -> 32'h80010000.
- Forwarding: sw with wd_m_i=1, rt=5, w_we_i=1, w_dst_i=5, w_data_i=7 -> memory holds 7. Repeat with w_dst_i=0 -> memory holds wd_m_i.
- Misaligned sw at 0x42 -> addr_err_o=1 and word 0x40 unchanged. Misaligned lh at 0x43 -> addr_err_o=1 and memrd_mw_o=0.
- Tnew 3 -> 2, 0 -> 0. Reset asserted while an sw is in M -> no write; outputs equal their reset values (pc_mw_o=32'h3000); a subsequent lw reads 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, field positions, memory-op decode.
package mips_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 26;
  localparam int unsigned RT_HI  = 20;
  localparam int unsigned RT_LO  = 16;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } mem_size_e;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    logic      sext;
    mem_size_e size;
  } mem_ctl_t;

  // Map an opcode to its data-memory access class; anything else is a non-memory op.
  function automatic mem_ctl_t decode_mem(input logic [5:0] opc);
    mem_ctl_t c;
    c = '{is_load: 1'b0, is_store: 1'b0, sext: 1'b0, size: SZ_NONE};
    case (opc)
      OP_LW:   c = '{is_load: 1'b1, is_store: 1'b0, sext: 1'b0, size: SZ_WORD};
      OP_LH:   c = '{is_load: 1'b1, is_store: 1'b0, sext: 1'b1, size: SZ_HALF};
      OP_LHU:  c = '{is_load: 1'b1, is_store: 1'b0, sext: 1'b0, size: SZ_HALF};
      OP_LB:   c = '{is_load: 1'b1, is_store: 1'b0, sext: 1'b1, size: SZ_BYTE};
      OP_LBU:  c = '{is_load: 1'b1, is_store: 1'b0, sext: 1'b0, size: SZ_BYTE};
      OP_SW:   c = '{is_load: 1'b0, is_store: 1'b1, sext: 1'b0, size: SZ_WORD};
      OP_SH:   c = '{is_load: 1'b0, is_store: 1'b1, sext: 1'b0, size: SZ_HALF};
      OP_SB:   c = '{is_load: 1'b0, is_store: 1'b1, sext: 1'b0, size: SZ_BYTE};
      default: c = '{is_load: 1'b0, is_store: 1'b0, sext: 1'b0, size: SZ_NONE};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dm_array.sv
// Data memory: DM_WORDS x 32, byte-enable writes, synchronous clear, combinational read.
module dm_array
  import mips_pkg::*;
#(
  parameter int unsigned DM_WORDS = 1024,
  parameter int unsigned DM_AW    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DM_AW-1:0]  idx_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DM_WORDS];

  // Clear every word on reset; otherwise commit enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Asynchronous read of the addressed word.
  always_comb begin
    rdata_o = mem_q[idx_i];
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS M stage: data-memory access with W->M store forwarding, feeding the M/W register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned DM_WORDS = 1024,
  parameter int unsigned DM_AW    = 10,
  parameter logic [31:0] PC_RESET = PC_RESET_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_m_i,
  input  logic [31:0] pc_m_i,
  input  logic [31:0] alurs_m_i,
  input  logic [31:0] wd_m_i,
  input  logic [4:0]  dst_m_i,
  input  logic [2:0]  tnew_m_i,
  input  logic        w_we_i,
  input  logic [4:0]  w_dst_i,
  input  logic [31:0] w_data_i,
  output logic [31:0] instr_mw_o,
  output logic [31:0] pc_mw_o,
  output logic [31:0] alurs_mw_o,
  output logic [31:0] memrd_mw_o,
  output logic [4:0]  dst_mw_o,
  output logic [2:0]  tnew_mw_o,
  output logic        addr_err_o
);

  mem_ctl_t          ctl;
  logic [1:0]        lane;
  logic [DM_AW-1:0]  widx;
  logic              addr_err;
  logic [31:0]       st_data;
  logic [3:0]        dm_be;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic [15:0]       ld_half;
  logic [7:0]        ld_byte;
  logic [31:0]       ld_ext;

  logic [31:0] instr_d, instr_q;
  logic [31:0] pc_d,    pc_q;
  logic [31:0] alurs_d, alurs_q;
  logic [31:0] memrd_d, memrd_q;
  logic [4:0]  dst_d,   dst_q;
  logic [2:0]  tnew_d,  tnew_q;

  // Decode the access, split the address and flag misalignment.
  always_comb begin
    ctl      = decode_mem(instr_m_i[OPC_HI:OPC_LO]);
    lane     = alurs_m_i[1:0];
    widx     = alurs_m_i[DM_AW+1:2];
    addr_err = ((ctl.size == SZ_WORD) && (lane != 2'b00)) ||
               ((ctl.size == SZ_HALF) && lane[0]);
  end

  assign addr_err_o = addr_err;

  // Pick store data, bypassing the register file when W is writing our rt.
  always_comb begin
    st_data = wd_m_i;
    if (w_we_i && (w_dst_i != '0) && (w_dst_i == instr_m_i[RT_HI:RT_LO])) begin
      st_data = w_data_i;
    end
  end

  // Build byte enables and lane-replicated write data; misaligned or reset-cycle stores are dropped.
  always_comb begin
    dm_be    = '0;
    dm_wdata = st_data;
    case (ctl.size)
      SZ_WORD: begin
        dm_be    = 4'b1111;
        dm_wdata = st_data;
      end
      SZ_HALF: begin
        dm_be    = lane[1] ? 4'b1100 : 4'b0011;
        dm_wdata = {2{st_data[15:0]}};
      end
      SZ_BYTE: begin
        dm_be    = 4'b0001 << lane;
        dm_wdata = {4{st_data[7:0]}};
      end
      default: begin
        dm_be    = '0;
        dm_wdata = st_data;
      end
    endcase
    if (!ctl.is_store || addr_err || reset) begin
      dm_be = '0;
    end
  end

  dm_array #(
    .DM_WORDS (DM_WORDS),
    .DM_AW    (DM_AW)
  ) u_dm (
    .clk     (clk),
    .reset   (reset),
    .idx_i   (widx),
    .be_i    (dm_be),
    .wdata_i (dm_wdata),
    .rdata_o (dm_rdata)
  );

  // Select the loaded lane and sign/zero extend; non-loads and misaligned loads yield 0.
  always_comb begin
    ld_half = lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (lane)
      2'd0:    ld_byte = dm_rdata[7:0];
      2'd1:    ld_byte = dm_rdata[15:8];
      2'd2:    ld_byte = dm_rdata[23:16];
      default: ld_byte = dm_rdata[31:24];
    endcase
    ld_ext = '0;
    if (ctl.is_load && !addr_err) begin
      case (ctl.size)
        SZ_WORD: ld_ext = dm_rdata;
        SZ_HALF: ld_ext = {{16{ctl.sext & ld_half[15]}}, ld_half};
        SZ_BYTE: ld_ext = {{24{ctl.sext & ld_byte[7]}}, ld_byte};
        default: ld_ext = '0;
      endcase
    end
  end

  // Next-state of the M/W register; Tnew counts down and saturates at zero.
  always_comb begin
    instr_d = instr_m_i;
    pc_d    = pc_m_i;
    alurs_d = alurs_m_i;
    memrd_d = ld_ext;
    dst_d   = dst_m_i;
    tnew_d  = (tnew_m_i != '0) ? (tnew_m_i - 3'd1) : '0;
  end

  // M/W pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= PC_RESET;
      alurs_q <= '0;
      memrd_q <= '0;
      dst_q   <= '0;
      tnew_q  <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      alurs_q <= alurs_d;
      memrd_q <= memrd_d;
      dst_q   <= dst_d;
      tnew_q  <= tnew_d;
    end
  end

  assign instr_mw_o = instr_q;
  assign pc_mw_o    = pc_q;
  assign alurs_mw_o = alurs_q;
  assign memrd_mw_o = memrd_q;
  assign dst_mw_o   = dst_q;
  assign tnew_mw_o  = tnew_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage against a byte-addressed memory model.
module tb_mem_stage;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SB  = 6'b101000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_m = '0, pc_m = '0, alurs_m = '0, wd_m = '0, w_data = '0;
  logic [4:0]  dst_m = '0, w_dst = '0;
  logic [2:0]  tnew_m = '0;
  logic        w_we = 1'b0;
  logic [31:0] instr_mw, pc_mw, alurs_mw, memrd_mw;
  logic [4:0]  dst_mw;
  logic [2:0]  tnew_mw;
  logic        addr_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  bmem [4096];
  logic [31:0] pc_ctr = 32'h0000_3000;

  always #5 clk = ~clk;

  mem_stage #(.DM_WORDS(1024), .DM_AW(10), .PC_RESET(32'h0000_3000)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_m_i  (instr_m),
    .pc_m_i     (pc_m),
    .alurs_m_i  (alurs_m),
    .wd_m_i     (wd_m),
    .dst_m_i    (dst_m),
    .tnew_m_i   (tnew_m),
    .w_we_i     (w_we),
    .w_dst_i    (w_dst),
    .w_data_i   (w_data),
    .instr_mw_o (instr_mw),
    .pc_mw_o    (pc_mw),
    .alurs_mw_o (alurs_mw),
    .memrd_mw_o (memrd_mw),
    .dst_mw_o   (dst_mw),
    .tnew_mw_o  (tnew_mw),
    .addr_err_o (addr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd3, rt, 16'h0040};
  endfunction

  // One instruction through M: check addr_err, clock, check M/W, then update the model.
  task automatic step(input logic [31:0] instr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic we, input logic [4:0] wdst, input logic [31:0] wdata,
                      input logic [2:0] tnew, input logic rst);
    int size, a;
    bit ld, st, sx, mis;
    logic [31:0] sdata, exp_rd, v;
    ld = 0; st = 0; sx = 0; size = 0;
    case (instr[31:26])
      LW:  begin ld = 1; size = 4; end
      LH:  begin ld = 1; size = 2; sx = 1; end
      LHU: begin ld = 1; size = 2; end
      LB:  begin ld = 1; size = 1; sx = 1; end
      LBU: begin ld = 1; size = 1; end
      SW:  begin st = 1; size = 4; end
      SH:  begin st = 1; size = 2; end
      SB:  begin st = 1; size = 1; end
      default: ;
    endcase
    a   = int'(addr[11:0]);
    mis = (size == 4 && (a % 4) != 0) || (size == 2 && (a % 2) != 0);
    sdata = (we && wdst != 0 && wdst == instr[20:16]) ? wdata : wd;
    exp_rd = 0;
    if (ld && !mis) begin
      v = 0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = bmem[a+i];
      if (size == 1)      exp_rd = sx ? {{24{v[7]}}, v[7:0]}   : {24'h0, v[7:0]};
      else if (size == 2) exp_rd = sx ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
      else                exp_rd = v;
    end

    instr_m = instr; pc_m = pc_ctr; alurs_m = addr; wd_m = wd;
    dst_m = instr[20:16]; tnew_m = tnew; w_we = we; w_dst = wdst; w_data = wdata; reset = rst;
    #1;
    chk("addr_err", {31'h0, addr_err}, {31'h0, mis});
    @(posedge clk);
    #1;
    if (rst) begin
      chk("rst_instr", instr_mw, 32'h0);
      chk("rst_pc",    pc_mw,    32'h0000_3000);
      chk("rst_alurs", alurs_mw, 32'h0);
      chk("rst_memrd", memrd_mw, 32'h0);
      chk("rst_dst",   {27'h0, dst_mw},  32'h0);
      chk("rst_tnew",  {29'h0, tnew_mw}, 32'h0);
      for (int i = 0; i < 4096; i++) bmem[i] = 8'h00;
    end else begin
      chk("instr", instr_mw, instr);
      chk("pc",    pc_mw,    pc_ctr);
      chk("alurs", alurs_mw, addr);
      chk("memrd", memrd_mw, exp_rd);
      chk("dst",   {27'h0, dst_mw},  {27'h0, instr[20:16]});
      chk("tnew",  {29'h0, tnew_mw}, (tnew != 0) ? 32'(tnew) - 32'd1 : 32'h0);
      if (st && !mis)
        for (int i = 0; i < size; i++) bmem[a+i] = sdata[8*i +: 8];
    end
    pc_ctr = pc_ctr + 32'd4;
  endtask

  initial begin
    logic [31:0] r, r2;
    logic [5:0] ops [9];
    ops = '{LW, LH, LHU, LB, LBU, SW, SH, SB, 6'h00};
    for (int i = 0; i < 4096; i++) bmem[i] = 8'h00;

    // reset
    step(32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 1);
    step(32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 1);

    // word store/load
    step(mk(SW, 5'd8), 32'h10, 32'hDEADBEEF, 0, 0, 0, 1, 0);
    step(mk(LW, 5'd9), 32'h10, 32'h0, 0, 0, 0, 1, 0);
    chk("lw_deadbeef", memrd_mw, 32'hDEADBEEF);

    // byte store/loads
    step(mk(SB, 5'd8), 32'h21, 32'h0000_0080, 0, 0, 0, 1, 0);
    step(mk(LB, 5'd9), 32'h21, 32'h0, 0, 0, 0, 1, 0);
    chk("lb_sext", memrd_mw, 32'hFFFFFF80);
    step(mk(LBU, 5'd9), 32'h21, 32'h0, 0, 0, 0, 1, 0);
    chk("lbu_zext", memrd_mw, 32'h00000080);
    step(mk(LW, 5'd9), 32'h20, 32'h0, 0, 0, 0, 1, 0);
    chk("lw_byte_lane", memrd_mw, 32'h00008000);

    // halfword store/loads
    step(mk(SH, 5'd8), 32'h32, 32'h0000_8001, 0, 0, 0, 1, 0);
    step(mk(LH, 5'd9), 32'h32, 32'h0, 0, 0, 0, 1, 0);
    chk("lh_sext", memrd_mw, 32'hFFFF8001);
    step(mk(LHU, 5'd9), 32'h32, 32'h0, 0, 0, 0, 1, 0);
    chk("lhu_zext", memrd_mw, 32'h00008001);
    step(mk(LW, 5'd9), 32'h30, 32'h0, 0, 0, 0, 1, 0);
    chk("lw_half_lane", memrd_mw, 32'h80010000);

    // forwarding from W
    step(mk(SW, 5'd5), 32'h50, 32'h1, 1, 5'd5, 32'h7, 0, 0);
    step(mk(LW, 5'd9), 32'h50, 32'h0, 0, 0, 0, 0, 0);
    chk("fwd_hit", memrd_mw, 32'h7);
    step(mk(SW, 5'd0), 32'h54, 32'h1, 1, 5'd0, 32'h7, 0, 0);
    step(mk(LW, 5'd9), 32'h54, 32'h0, 0, 0, 0, 0, 0);
    chk("fwd_r0", memrd_mw, 32'h1);

    // misalignment
    step(mk(SW, 5'd8), 32'h40, 32'h11223344, 0, 0, 0, 0, 0);
    step(mk(SW, 5'd8), 32'h42, 32'hAAAAAAAA, 0, 0, 0, 0, 0);
    chk("mis_sw_err", {31'h0, addr_err}, 32'h1);
    step(mk(LW, 5'd9), 32'h40, 32'h0, 0, 0, 0, 0, 0);
    chk("mis_sw_nowrite", memrd_mw, 32'h11223344);
    step(mk(LH, 5'd9), 32'h43, 32'h0, 0, 0, 0, 0, 0);
    chk("mis_lh_zero", memrd_mw, 32'h0);

    // Tnew countdown
    step(32'h0, 32'h0, 32'h0, 0, 0, 0, 3'd3, 0);
    chk("tnew_3", {29'h0, tnew_mw}, 32'h2);
    step(32'h0, 32'h0, 32'h0, 0, 0, 0, 3'd0, 0);
    chk("tnew_0", {29'h0, tnew_mw}, 32'h0);

    // reset with a store in M, then reload
    step(mk(SW, 5'd8), 32'h60, 32'hCAFEF00D, 0, 0, 0, 2, 1);
    step(mk(LW, 5'd9), 32'h60, 32'h0, 0, 0, 0, 0, 0);
    chk("rst_store_dropped", memrd_mw, 32'h0);
    step(mk(LW, 5'd9), 32'h10, 32'h0, 0, 0, 0, 0, 0);
    chk("rst_cleared", memrd_mw, 32'h0);

    // address wrap: upper bits ignored
    step(mk(SW, 5'd8), 32'hFFFF_F070, 32'h01020304, 0, 0, 0, 0, 0);
    step(mk(LW, 5'd9), 32'h0000_0070, 32'h0, 0, 0, 0, 0, 0);
    chk("wrap", memrd_mw, 32'h01020304);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      r  = $urandom;
      r2 = $urandom;
      step({ops[$urandom_range(0, 8)], r[25:21], 2'b00, r[18:16], r[15:0]},
           (r2 & 32'hFFFF_F000) | 32'($urandom_range(0, 63)),
           $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           3'($urandom_range(0, 7)), ($urandom_range(0, 59) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
